vga_scene_sequencer: RTL and testbench
======================================

Name: vga_scene_sequencer

Overview:
Frame-synchronous controller that sequences the VGA pattern generator.
- Derives a one-cycle frame tick from vsync.
- Debounces three user buttons and drives the pattern datapath's configuration: scene select, scroll offset, scroll speed and fade level.
- Runs an auto-advance/fade/pause state machine, so every visible change lands on a frame boundary with no mid-frame tearing.

Parameters:
- VSYNC_ACTIVE_HIGH, 0: 1 means vsync pulse is high; 0 means vsync pulse is low.
- DEBOUNCE_CYCLES, 250000: clk cycles a synchronized button must be stable before its level is accepted (min 2).
- SCENE_FRAMES, 600: frames spent in RUN before auto-advance when auto_en=1 (min 1).
- FADE_STEP_FRAMES, 4: frames per fade level step (min 1).

Ports:
- clk, input, 1: pixel clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- vsync, input, 1: vsync from the sync generator, same clock domain.
- btn_next, input, 1: raw button; request next scene.
- btn_pause, input, 1: raw button; toggle pause.
- btn_speed, input, 1: raw button; cycle scroll speed.
- auto_en, input, 1: level; enables timed auto-advance. Sampled at frame tick.
- frame_tick, output, 1: one-cycle pulse at the start of each vsync pulse.
- scene, output, 2: active pattern index, 0..3.
- scroll_offset, output, 10: animation offset added to the pattern coordinates.
- speed_sel, output, 2: scroll step = 1 << speed_sel (1, 2, 4 or 8).
- fade_level, output, 2: 3 = full brightness, 0 = black. The datapath masks colour bits with it.
- paused, output, 1: high in PAUSE state.

Behaviour:
- Reset (async, rst_n=0): frame_tick=0, scene=0, scroll_offset=0, speed_sel=0, fade_level=3, paused=0, state=RUN. All counters, pending flags and debounce state are 0.
- Frame tick:
  - vsync is registered once, then normalized by VSYNC_ACTIVE_HIGH to active-high.
  - frame_tick=1 in the cycle after the first clock edge that samples the active level following an inactive sample. It lasts exactly 1 cycle.
- Buttons:
  - Each button passes through a 2-FF synchronizer.
  - Its debounce counter reloads on any change and increments while stable. When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value.
  - A 0->1 debounced transition sets that button's pending flag. Flags are sticky and are all cleared at the next frame_tick edge, whether consumed or not.
  - A press and a frame_tick in the same cycle: the press stays pending for the following tick.
- All state/output updates below happen only on clock edges where frame_tick=1. Outputs are therefore stable for the whole following frame.
- speed pending (any state): speed_sel increments, wrapping 3->0.
- Scroll: in RUN, FADE_OUT and FADE_IN, scroll_offset += 1<<speed_sel, mod 1024 (wraps naturally). Frozen in PAUSE. If a speed change and a scroll step occur at the same tick, the step uses the old speed_sel.
- FSM states RUN, PAUSE, FADE_OUT, FADE_IN, evaluated in priority order below.
- RUN:
  - pause pending -> PAUSE; dwell counter cleared.
  - Else next pending -> FADE_OUT.
  - Else if auto_en=1 and the dwell counter reaches SCENE_FRAMES-1 -> FADE_OUT.
  - Else dwell += 1 (dwell counts only while auto_en=1; cleared when auto_en=0).
- PAUSE:
  - pause pending -> RUN, dwell=0.
  - next is ignored (flag cleared).
- FADE_OUT:
  - Step counter counts FADE_STEP_FRAMES ticks. Then fade_level -= 1.
  - When fade_level would go below 0, i.e. on the step after reaching 0: scene += 1 (wrap 3->0), -> FADE_IN.
- FADE_IN: fade_level += 1 per FADE_STEP_FRAMES ticks. The step after reaching 3 -> RUN, dwell=0.
- During fades, pause and next are ignored (flags cleared).
- fade_level is 3 in RUN and PAUSE. scene only changes while fade_level=0.
- Reset mid-fade or mid-debounce returns everything immediately to reset values. No partial press is emitted after release.
- auto_en toggling mid-dwell: dwell clears at the tick where auto_en is sampled 0.

Test Plan:
Use DEBOUNCE_CYCLES=4, SCENE_FRAMES=8, FADE_STEP_FRAMES=1 and short synthetic frames (100 clk period, 10 clk vsync pulse) unless stated.
- Frame tick: VSYNC_ACTIVE_HIGH=0, 5 frames, no buttons -> frame_tick exactly 1 cycle per frame, 5 pulses. scroll_offset reads 1,2,3,4,5 after each tick. scene=0, fade_level=3.
- Debounce: btn_next bounces 0/1 every 2 clk for 20 clk, then holds 1 -> exactly one press. At the next tick FSM enters FADE_OUT. fade_level goes 2,1,0 on successive ticks, then scene=1 and FADE_IN. fade_level 1,2,3, then RUN.
- Pause: press pause -> paused=1 after the next tick. scroll_offset is held for 10 frames. Next press in PAUSE has no effect. Second pause press -> paused=0 and scrolling resumes.
- Speed and wrap: 3 speed presses -> speed_sel=3, step 8. Preload by running until scroll_offset=1016 -> next tick gives 0 (wrap mod 1024). Fourth press -> speed_sel=0.
- Auto-advance: auto_en=1 -> FADE_OUT begins at the 8th tick in RUN, and the scene sequence 0->1->2->3->0 completes. Pause and next pressed in the same frame -> PAUSE, no fade.
- Async reset asserted while fade_level=1 in FADE_OUT -> immediately scene=0, fade_level=3, offset=0, paused=0, frame_tick=0. The first tick after release resumes RUN.

Source files
------------

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous controller for the VGA pattern generator: frame tick, button debounce,
// and a run/pause/fade FSM whose visible outputs only change on frame boundaries.
module vga_scene_sequencer #(
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned SCENE_FRAMES      = 600,
    parameter int unsigned FADE_STEP_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       btn_next,
    input  logic       btn_pause,
    input  logic       btn_speed,
    input  logic       auto_en,
    output logic       frame_tick,
    output logic [1:0] scene,
    output logic [9:0] scroll_offset,
    output logic [1:0] speed_sel,
    output logic [1:0] fade_level,
    output logic       paused
);

    localparam int unsigned NumBtn   = 3;
    localparam int unsigned BtnNext  = 0;
    localparam int unsigned BtnPause = 1;
    localparam int unsigned BtnSpeed = 2;

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DwellW = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
    localparam int unsigned StepW  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

    localparam logic [DbW-1:0]    DbMax     = DbW'(DEBOUNCE_CYCLES);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCENE_FRAMES - 1);
    localparam logic [StepW-1:0]  StepLast  = StepW'(FADE_STEP_FRAMES - 1);

    typedef enum logic [1:0] {
        StRun,
        StPause,
        StFadeOut,
        StFadeIn
    } state_e;

    // ------------------------------------------------------------------------------------------
    // Frame tick: vsync normalised to active-high, tick on the first active sample.
    // ------------------------------------------------------------------------------------------
    logic vs_q;
    logic vs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_q      <= VSYNC_ACTIVE_HIGH ? vsync : ~vsync;
            vs_prev_q <= vs_q;
        end
    end

    assign frame_tick = vs_q & ~vs_prev_q;

    // ------------------------------------------------------------------------------------------
    // Button synchronisers, debouncers and sticky per-frame pending flags.
    // ------------------------------------------------------------------------------------------
    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    logic [NumBtn-1:0] last_q;
    logic [NumBtn-1:0] db_q;
    logic [NumBtn-1:0] db_d;
    logic [NumBtn-1:0] pend_q;
    logic [NumBtn-1:0] pend_d;
    logic [NumBtn-1:0] rise;
    logic [DbW-1:0]    db_cnt_q [NumBtn];
    logic [DbW-1:0]    db_cnt_d [NumBtn];

    assign btn_raw = {btn_speed, btn_pause, btn_next};

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NumBtn; i++) begin
            if (sync2_q[i] != last_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbMax) begin
                db_d[i] = last_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
        rise = db_d & ~db_q;
        // A press landing on the tick edge itself survives into the next frame.
        pend_d = frame_tick ? rise : (pend_q | rise);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            db_q    <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            db_q     <= db_d;
            pend_q   <= pend_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Scene FSM and pattern configuration, all updated on frame_tick only.
    // ------------------------------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [1:0]        scene_q;
    logic [1:0]        scene_d;
    logic [9:0]        offset_q;
    logic [9:0]        offset_d;
    logic [1:0]        speed_q;
    logic [1:0]        speed_d;
    logic [1:0]        fade_q;
    logic [1:0]        fade_d;
    logic [DwellW-1:0] dwell_q;
    logic [DwellW-1:0] dwell_d;
    logic [StepW-1:0]  step_q;
    logic [StepW-1:0]  step_d;
    logic              step_hit;

    assign step_hit = (step_q == StepLast);

    always_comb begin
        state_d  = state_q;
        scene_d  = scene_q;
        offset_d = offset_q;
        speed_d  = speed_q;
        fade_d   = fade_q;
        dwell_d  = dwell_q;
        step_d   = step_q;

        if (frame_tick) begin
            if (pend_q[BtnSpeed]) begin
                speed_d = speed_q + 2'd1;
            end
            // Scroll step uses the speed in force before this tick.
            if (state_q != StPause) begin
                offset_d = offset_q + (10'd1 << speed_q);
            end

            unique case (state_q)
                StRun: begin
                    step_d = '0;
                    if (pend_q[BtnPause]) begin
                        state_d = StPause;
                        dwell_d = '0;
                    end else if (pend_q[BtnNext]) begin
                        state_d = StFadeOut;
                    end else if (auto_en && (dwell_q == DwellLast)) begin
                        state_d = StFadeOut;
                    end else if (auto_en) begin
                        dwell_d = dwell_q + DwellW'(1);
                    end else begin
                        dwell_d = '0;
                    end
                end
                StPause: begin
                    if (pend_q[BtnPause]) begin
                        state_d = StRun;
                        dwell_d = '0;
                    end
                end
                StFadeOut: begin
                    if (step_hit) begin
                        step_d = '0;
                        if (fade_q == 2'd0) begin
                            scene_d = scene_q + 2'd1;
                            state_d = StFadeIn;
                        end else begin
                            fade_d = fade_q - 2'd1;
                        end
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
                StFadeIn: begin
                    if (step_hit) begin
                        step_d = '0;
                        if (fade_q == 2'd3) begin
                            state_d = StRun;
                            dwell_d = '0;
                        end else begin
                            fade_d = fade_q + 2'd1;
                        end
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            scene_q  <= 2'd0;
            offset_q <= 10'd0;
            speed_q  <= 2'd0;
            fade_q   <= 2'd3;
            dwell_q  <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            offset_q <= offset_d;
            speed_q  <= speed_d;
            fade_q   <= fade_d;
            dwell_q  <= dwell_d;
            step_q   <= step_d;
        end
    end

    assign scene         = scene_q;
    assign scroll_offset = offset_q;
    assign speed_sel     = speed_q;
    assign fade_level    = fade_q;
    assign paused        = (state_q == StPause);

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Bench for vga_scene_sequencer: a directed frame table, hand-written corner sequences and
// randomised frames checked against a frame-level reference model.
module tb_vga_scene_sequencer;

    localparam int unsigned DB = 4;
    localparam int unsigned SF = 8;
    localparam int unsigned FS = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_speed = 1'b0;
    logic       auto_en = 1'b0;
    logic       frame_tick;
    logic [1:0] scene;
    logic [9:0] scroll_offset;
    logic [1:0] speed_sel;
    logic [1:0] fade_level;
    logic       paused;

    always #5 clk = ~clk;

    vga_scene_sequencer #(
        .VSYNC_ACTIVE_HIGH (1'b0),
        .DEBOUNCE_CYCLES   (DB),
        .SCENE_FRAMES      (SF),
        .FADE_STEP_FRAMES  (FS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .btn_next      (btn_next),
        .btn_pause     (btn_pause),
        .btn_speed     (btn_speed),
        .auto_en       (auto_en),
        .frame_tick    (frame_tick),
        .scene         (scene),
        .scroll_offset (scroll_offset),
        .speed_sel     (speed_sel),
        .fade_level    (fade_level),
        .paused        (paused)
    );

    // press bits: [0]=next [1]=pause [2]=speed; expected values are read after that frame's tick
    typedef struct {
        logic [2:0] press;
        logic       auto_v;
        int         sc;
        int         off;
        int         spd;
        int         fd;
        int         p;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int tick_cnt = 0;
    int last_ticks = 0;

    always @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

    // Reference model: per-frame rules; a fade is a precomputed queue of (fade, scene) per tick.
    int         m_scene, m_off, m_spd, m_fade, m_dwell;
    bit         m_paused;
    int         fq[$];
    int         sq[$];
    logic [2:0] pend;

    function automatic void model_reset();
        m_scene = 0; m_off = 0; m_spd = 0; m_fade = 3; m_dwell = 0; m_paused = 0;
        fq.delete(); sq.delete(); pend = 3'b000;
    endfunction

    function automatic void plan_fade();
        int lv = 3;
        int sc = m_scene;
        for (int s = 0; s < 8; s++) begin
            for (int k = 1; k < FS; k++) begin
                fq.push_back(lv); sq.push_back(sc);
            end
            if (s < 3) lv--;
            else if (s == 3) sc = (sc + 1) % 4;
            else if (s < 7) lv++;
            fq.push_back(lv); sq.push_back(sc);
        end
    endfunction

    function automatic void model_tick(logic a);
        int old = m_spd;
        if (pend[2]) m_spd = (m_spd + 1) % 4;
        if (!m_paused) m_off = (m_off + (1 << old)) % 1024;
        if (fq.size() > 0) begin
            m_fade  = fq.pop_front();
            m_scene = sq.pop_front();
            if (fq.size() == 0) m_dwell = 0;
        end else if (m_paused) begin
            if (pend[1]) begin m_paused = 0; m_dwell = 0; end
        end else if (pend[1]) begin
            m_paused = 1; m_dwell = 0;
        end else if (pend[0] || (a && m_dwell == SF - 1)) begin
            plan_fade();
        end else begin
            m_dwell = a ? m_dwell + 1 : 0;
        end
        pend = 3'b000;
    endfunction

    task automatic cmp(input string tag, input string what, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s %s: got %0d want %0d", tag, what, got, want);
        end
    endtask

    task automatic check_out(input string tag, input int sc, input int off, input int spd,
                             input int fd, input int p);
        cmp(tag, "scene", int'(scene), sc);
        cmp(tag, "scroll_offset", int'(scroll_offset), off);
        cmp(tag, "speed_sel", int'(speed_sel), spd);
        cmp(tag, "fade_level", int'(fade_level), fd);
        cmp(tag, "paused", int'(paused), p);
    endtask

    // One 100-clock frame: vsync low for 10 clocks, check at clock 15, buttons at 20..69.
    // bounce: 0 = plain press, 1 = next bounces then holds, 2 = next bounces then released.
    task automatic do_frame(input logic [2:0] press, input logic auto_v, input int bounce,
                            input bit use_tab, input vec_t tv, input string tag);
        model_tick(auto_en);
        for (int c = 0; c < 100; c++) begin
            vsync = (c < 10) ? 1'b0 : 1'b1;
            if (c == 15) begin
                cmp(tag, "frame_tick pulses", tick_cnt - last_ticks, 1);
                last_ticks = tick_cnt;
                if (use_tab) check_out(tag, tv.sc, tv.off, tv.spd, tv.fd, tv.p);
                else check_out(tag, m_scene, m_off, m_spd, m_fade, int'(m_paused));
            end
            if (c == 16) auto_en = auto_v;
            if (c >= 20 && c < 40) begin
                if (bounce != 0) btn_next = ((c / 2) % 2) == 1;
                else {btn_speed, btn_pause, btn_next} = press;
            end else if (c >= 40 && c < 70) begin
                btn_next = (bounce == 1); btn_pause = 1'b0; btn_speed = 1'b0;
            end else begin
                {btn_speed, btn_pause, btn_next} = 3'b000;
            end
            @(posedge clk); #1;
        end
        pend = press | ((bounce == 1) ? 3'b001 : 3'b000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b1;
        {btn_speed, btn_pause, btn_next} = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (10) begin @(posedge clk); #1; end
        last_ticks = tick_cnt;
    endtask

    function automatic vec_t mk(input int pr, input int a, input int sc, input int off,
                                input int spd, input int fd, input int p);
        vec_t v;
        v.press = 3'(pr); v.auto_v = 1'(a);
        v.sc = sc; v.off = off; v.spd = spd; v.fd = fd; v.p = p;
        return v;
    endfunction

    vec_t tab[22];
    vec_t none;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           press auto sc off spd fd p
        tab[0]  = mk(3'b001, 0, 0,  1, 0, 3, 0);
        tab[1]  = mk(3'b000, 0, 0,  2, 0, 3, 0);
        tab[2]  = mk(3'b000, 0, 0,  3, 0, 2, 0);
        tab[3]  = mk(3'b000, 0, 0,  4, 0, 1, 0);
        tab[4]  = mk(3'b000, 0, 0,  5, 0, 0, 0);
        tab[5]  = mk(3'b000, 0, 1,  6, 0, 0, 0);
        tab[6]  = mk(3'b010, 0, 1,  7, 0, 1, 0);
        tab[7]  = mk(3'b000, 0, 1,  8, 0, 2, 0);
        tab[8]  = mk(3'b000, 0, 1,  9, 0, 3, 0);
        tab[9]  = mk(3'b010, 0, 1, 10, 0, 3, 0);
        tab[10] = mk(3'b001, 0, 1, 11, 0, 3, 1);
        tab[11] = mk(3'b100, 0, 1, 11, 0, 3, 1);
        tab[12] = mk(3'b010, 0, 1, 11, 1, 3, 1);
        tab[13] = mk(3'b000, 0, 1, 11, 1, 3, 0);
        tab[14] = mk(3'b100, 0, 1, 13, 1, 3, 0);
        tab[15] = mk(3'b100, 0, 1, 15, 2, 3, 0);
        tab[16] = mk(3'b100, 0, 1, 19, 3, 3, 0);
        tab[17] = mk(3'b000, 0, 1, 27, 0, 3, 0);
        tab[18] = mk(3'b011, 0, 1, 28, 0, 3, 0);
        tab[19] = mk(3'b010, 0, 1, 29, 0, 3, 1);
        tab[20] = mk(3'b000, 0, 1, 29, 0, 3, 0);
        tab[21] = mk(3'b000, 0, 1, 30, 0, 3, 0);
        none = mk(0, 0, 0, 0, 0, 0, 0);

        // Reset state, sampled while reset is held.
        #12;
        cmp("reset", "frame_tick", int'(frame_tick), 0);
        check_out("reset", 0, 0, 0, 3, 0);
        do_reset();

        // Directed table.
        for (int i = 0; i < 22; i++) begin
            do_frame(tab[i].press, tab[i].auto_v, 0, 1'b1, tab[i], $sformatf("tab%0d", i));
        end

        // Bounce that settles released must not register; bounce that settles pressed once.
        do_reset();
        do_frame(3'b000, 1'b0, 2, 1'b0, none, "bounce_rel");
        do_frame(3'b000, 1'b0, 1, 1'b0, none, "bounce_hold");
        for (int i = 0; i < 10; i++) do_frame(3'b000, 1'b0, 0, 1'b0, none, "bounce_fade");
        cmp("bounce", "scene after fade", int'(scene), 1);

        // Auto-advance through all four scenes and back to 0.
        do_reset();
        do_frame(3'b000, 1'b1, 0, 1'b0, none, "auto_en");
        for (int i = 0; i < 66; i++) do_frame(3'b000, 1'b1, 0, 1'b0, none, "auto");
        cmp("auto", "scene wrapped", int'(scene), 0);

        // Asynchronous reset while fading out at fade_level 1.
        do_reset();
        do_frame(3'b001, 1'b0, 0, 1'b0, none, "rst_fade_go");
        for (int i = 0; i < 8 && !(m_fade == 1 && m_scene == 0 && fq.size() > 0); i++) begin
            do_frame(3'b000, 1'b0, 0, 1'b0, none, "rst_fade");
        end
        cmp("rst_fade", "fade before reset", int'(fade_level), 1);
        rst_n = 1'b0;
        #1;
        cmp("rst_fade", "frame_tick", int'(frame_tick), 0);
        check_out("rst_fade_now", 0, 0, 0, 3, 0);
        do_reset();
        do_frame(3'b000, 1'b0, 0, 1'b0, none, "rst_resume");
        cmp("rst_resume", "offset", int'(scroll_offset), 1);

        // Randomised frames against the model.
        do_reset();
        begin
            logic a = 1'b1;
            for (int i = 0; i < 150; i++) begin
                logic [2:0] pr;
                pr[0] = ($urandom_range(0, 5) == 0);
                pr[1] = ($urandom_range(0, 7) == 0);
                pr[2] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0) a = ~a;
                do_frame(pr, a, 0, 1'b0, none, $sformatf("rand%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
